// File: rtl/ifetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  localparam int LINE_OFF_W     = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_SEL_W     = 2;

endpackage

// File: rtl/ifetch_resp_if.sv
// Fetch-request handshake plus the simple read bus toward the AXI bridge.
interface ifetch_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_valid;
  logic [19:0]       inst_tag;
  logic [7:0]        inst_index;
  logic [3:0]        inst_offset;
  logic              inst_uncache;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              rd_req;
  logic [2:0]        rd_type;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [DATA_W-1:0] ret_data;

  // Responder side.
  modport slave (
    input  inst_valid, inst_tag, inst_index, inst_offset, inst_uncache, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data
  );

  // Fetch stage plus bus bridge, as seen from the environment.
  modport master (
    output inst_valid, inst_tag, inst_index, inst_offset, inst_uncache, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data
  );
endinterface

// File: rtl/ifetch_line_buf.sv
// One-entry 16-byte line buffer: storage, tag compare and refill beat counter.
module ifetch_line_buf
  import ifetch_resp_pkg::*;
#(
  parameter int TAG_W  = 28,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_W-1:0]      lookup_tag,
  input  logic [WORD_SEL_W-1:0] lookup_sel,
  output logic                  hit,
  output logic [DATA_W-1:0]     hit_word,
  input  logic                  fill_en,
  input  logic                  fill_last,
  input  logic [DATA_W-1:0]     fill_data,
  input  logic [TAG_W-1:0]      fill_tag,
  output logic [WORD_SEL_W-1:0] beat_idx
);

  logic                  lb_valid;
  logic [TAG_W-1:0]      lb_tag;
  logic [DATA_W-1:0]     words [WORDS_PER_LINE];
  logic [WORD_SEL_W-1:0] cnt;

  assign hit      = lb_valid && (lb_tag == lookup_tag);
  assign hit_word = words[lookup_sel];
  assign beat_idx = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lb_valid <= 1'b0;
      lb_tag   <= '0;
      cnt      <= '0;
    end else if (fill_en) begin
      cnt <= fill_last ? '0 : cnt + 2'd1;
      // Tag only becomes valid once the whole line has landed.
      if (fill_last) begin
        lb_valid <= 1'b1;
        lb_tag   <= fill_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) words[cnt] <= fill_data;
  end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: one outstanding request, word reads on the bus.
// Optional line buffer enabled by defining IFETCH_LINE_BUF_EN.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_resp_if.slave fetch
);

  state_e            state, nxt;
  logic [ADDR_W-1:0] paddr, paddr_q;
  logic              line_q, line_req;
  logic              cancel_r;
  logic [DATA_W-1:0] rdata_q;
  logic              accept, beat, capture;
  logic              lb_hit;
  logic [DATA_W-1:0] lb_word;

  assign paddr  = {fetch.inst_tag, fetch.inst_index, fetch.inst_offset};
  assign accept = rst && (state == IDLE) && fetch.inst_valid && !fetch.inst_cancel;
  assign beat   = (state == WAIT) && fetch.ret_valid;

`ifdef IFETCH_LINE_BUF_EN
  logic                  lb_hit_raw;
  logic [WORD_SEL_W-1:0] beat_idx;

  ifetch_line_buf #(
    .TAG_W  (ADDR_W - LINE_OFF_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (paddr[ADDR_W-1:LINE_OFF_W]),
    .lookup_sel (paddr[LINE_OFF_W-1:2]),
    .hit        (lb_hit_raw),
    .hit_word   (lb_word),
    .fill_en    (beat && line_q),
    .fill_last  (fetch.ret_last),
    .fill_data  (fetch.ret_data),
    .fill_tag   (paddr_q[ADDR_W-1:LINE_OFF_W]),
    .beat_idx   (beat_idx)
  );

  // Uncached requests never look at the buffer.
  assign lb_hit   = lb_hit_raw && !fetch.inst_uncache;
  assign line_req = !fetch.inst_uncache;
  assign capture  = beat && (!line_q || (beat_idx == paddr_q[LINE_OFF_W-1:2]));
`else
  logic unused_uncache;

  assign unused_uncache = fetch.inst_uncache;
  assign lb_hit         = 1'b0;
  assign lb_word        = '0;
  assign line_req       = 1'b0;
  assign capture        = beat;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = lb_hit ? DONE : ISSUE;
      ISSUE:   if (fetch.rd_rdy) nxt = WAIT;
      WAIT:    if (fetch.ret_valid && fetch.ret_last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign fetch.inst_addr_ok = accept;
  assign fetch.inst_data_ok = (state == DONE) && !(cancel_r || fetch.inst_cancel);
  assign fetch.inst_rdata   = rdata_q;
  assign fetch.rd_req       = (state == ISSUE);
  assign fetch.rd_type      = (state != ISSUE) ? 3'b000 :
                              line_q ? RD_TYPE_LINE : RD_TYPE_WORD;
  assign fetch.rd_addr      = (state != ISSUE) ? '0 :
                              line_q ? {paddr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}}
                                     : paddr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      paddr_q  <= '0;
      line_q   <= 1'b0;
      cancel_r <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        paddr_q <= paddr;
        line_q  <= line_req;
        if (lb_hit) rdata_q <= lb_word;
      end
      if (capture) rdata_q <= fetch.ret_data;
      // Cancel only masks data_ok; the bus transaction always runs to completion.
      if (nxt == IDLE)
        cancel_r <= 1'b0;
      else if ((state != IDLE) && fetch.inst_cancel)
        cancel_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp with a data_ok scoreboard.
module tb_ifetch_resp;
  import ifetch_resp_pkg::*;

`ifdef IFETCH_LINE_BUF_EN
  localparam bit UNC = 1'b1;
`else
  localparam bit UNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  ifetch_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_resp #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    bus.inst_tag    = a[31:12];
    bus.inst_index  = a[11:4];
    bus.inst_offset = a[3:0];
  endtask

  // Word-path fetch: addr_ok at T, data_ok at T+3+rdy_wait.
  task automatic word_fetch(input logic [31:0] a, input logic [31:0] d, input bit unc,
                            input int rdy_wait);
    bus.inst_valid = 1'b1;
    bus.inst_uncache = unc;
    set_addr(a);
    settle();
    chk("addr_ok", bus.inst_addr_ok, 1);
    sb.push_back(d);
    step();
    for (int i = 0; i < rdy_wait; i++) begin
      bus.rd_rdy = 1'b0;
      settle();
      chk("rd_req_hold", bus.rd_req, 1);
      chk("rd_addr_hold", bus.rd_addr, a);
      chk("addr_ok_busy", bus.inst_addr_ok, 0);
      step();
    end
    bus.rd_rdy = 1'b1;
    settle();
    chk("rd_req", bus.rd_req, 1);
    chk("rd_addr", bus.rd_addr, a);
    chk("rd_type", bus.rd_type, RD_TYPE_WORD);
    step();
    bus.rd_rdy    = 1'b0;
    bus.ret_valid = 1'b1;
    bus.ret_last  = 1'b1;
    bus.ret_data  = d;
    settle();
    chk("data_ok_early", bus.inst_data_ok, 0);
    step();
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    settle();
    chk("data_ok", bus.inst_data_ok, 1);
    step();
    bus.inst_valid = 1'b0;
    settle();
    chk("data_ok_pulse", bus.inst_data_ok, 0);
  endtask

  // Request that runs to the WAIT state and stops there (caller finishes it).
  task automatic start_to_wait(input logic [31:0] a);
    bus.inst_valid   = 1'b1;
    bus.inst_uncache = UNC;
    set_addr(a);
    settle();
    chk("addr_ok_start", bus.inst_addr_ok, 1);
    step();
    bus.rd_rdy = 1'b1;
    step();
    bus.rd_rdy = 1'b0;
  endtask

  // Monitor: every data_ok must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.inst_data_ok) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_ok: got rdata %h expected no data_ok", bus.inst_rdata);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        if (bus.inst_rdata !== exp) begin
          errors++;
          $display("FAIL sb_rdata: got %h expected %h", bus.inst_rdata, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inst_valid = 0; bus.inst_tag = 0; bus.inst_index = 0; bus.inst_offset = 0;
    bus.inst_uncache = 0; bus.inst_cancel = 0; bus.rd_rdy = 0;
    bus.ret_valid = 0; bus.ret_last = 0; bus.ret_data = 0;
    step();
    step();
    rst = 1'b1;
    settle();
    chk("rst_addr_ok", bus.inst_addr_ok, 0);
    chk("rst_data_ok", bus.inst_data_ok, 0);
    chk("rst_rdata", bus.inst_rdata, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_type", bus.rd_type, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    step();

    // Basic fetch, minimum latency.
    word_fetch(32'h1C00_0000, 32'h0280_0C21, UNC, 0);

    // Stray return beat in IDLE is ignored.
    bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'hDEAD_BEEF;
    step();
    bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
    settle();
    chk("stray_ret_rdata", bus.inst_rdata, 32'h0280_0C21);
    step();

    // Bus backpressure.
    word_fetch(32'h1C00_0100, 32'h2402_0005, UNC, 5);

    // Cancel pulse in WAIT: beat drained, no data_ok.
    start_to_wait(32'h1C00_0000);
    bus.inst_cancel = 1'b1;
    bus.inst_valid  = 1'b0;
    step();
    bus.inst_cancel = 1'b0;
    bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'hBAD0_0001;
    step();
    bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
    settle();
    chk("cancel_wait_data_ok", bus.inst_data_ok, 0);
    step();
    word_fetch(32'h1C00_0004, 32'h3C08_1234, UNC, 0);

    // Cancel in the DONE cycle.
    start_to_wait(32'h1C00_0010);
    bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'hBAD0_0002;
    step();
    bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
    bus.inst_cancel = 1'b1;
    settle();
    chk("cancel_done_data_ok", bus.inst_data_ok, 0);
    step();
    bus.inst_cancel = 1'b0;
    bus.inst_valid  = 1'b0;

    // Cancel together with valid in IDLE.
    bus.inst_valid = 1'b1; bus.inst_cancel = 1'b1;
    set_addr(32'h1C00_0020);
    settle();
    chk("idle_cancel_addr_ok", bus.inst_addr_ok, 0);
    step();
    settle();
    chk("idle_cancel_rd_req", bus.rd_req, 0);
    bus.inst_valid = 1'b0; bus.inst_cancel = 1'b0;
    step();

    // Reset in WAIT.
    start_to_wait(32'h1C00_0040);
    rst = 1'b0;
    bus.inst_valid = 1'b0;
    step();
    rst = 1'b1;
    settle();
    chk("mid_rst_addr_ok", bus.inst_addr_ok, 0);
    chk("mid_rst_data_ok", bus.inst_data_ok, 0);
    chk("mid_rst_rdata", bus.inst_rdata, 0);
    chk("mid_rst_rd_req", bus.rd_req, 0);
    chk("mid_rst_rd_type", bus.rd_type, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    step();
    word_fetch(32'h1C00_0044, 32'h0000_0013, UNC, 0);

`ifdef IFETCH_LINE_BUF_EN
    begin
      logic [31:0] beats [4];
      beats[0] = 32'hA000_000A; beats[1] = 32'hB000_000B;
      beats[2] = 32'hC000_000C; beats[3] = 32'hD000_000D;
      // Line miss: target word 2 of 0x1C00_0000.
      bus.inst_valid = 1'b1; bus.inst_uncache = 1'b0;
      set_addr(32'h1C00_0008);
      settle();
      chk("lb_miss_addr_ok", bus.inst_addr_ok, 1);
      sb.push_back(beats[2]);
      step();
      bus.rd_rdy = 1'b1;
      settle();
      chk("lb_rd_type", bus.rd_type, RD_TYPE_LINE);
      chk("lb_rd_addr", bus.rd_addr, 32'h1C00_0000);
      step();
      bus.rd_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        bus.ret_valid = 1'b1; bus.ret_last = (k == 3); bus.ret_data = beats[k];
        step();
      end
      bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
      settle();
      chk("lb_miss_data_ok", bus.inst_data_ok, 1);
      step();
      bus.inst_valid = 1'b0;
      step();
      // Hit: data_ok at T+1, no bus read.
      bus.inst_valid = 1'b1;
      set_addr(32'h1C00_000C);
      settle();
      chk("lb_hit_addr_ok", bus.inst_addr_ok, 1);
      sb.push_back(beats[3]);
      step();
      settle();
      chk("lb_hit_data_ok", bus.inst_data_ok, 1);
      chk("lb_hit_rd_req", bus.rd_req, 0);
      step();
      bus.inst_valid = 1'b0;
      step();
      // Uncached fetch of the same address goes to the bus as a word read.
      word_fetch(32'h1C00_000C, 32'hE000_000E, 1'b1, 0);
      step();
    end
`endif

    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
Name: ifetch_resp

Overview:
- Responder end of the instruction-fetch request interface.
- Accepts one fetch request at a time from the fetch stage (valid plus physical tag/index/offset) and answers with a one-cycle addr_ok, then a one-cycle data_ok carrying the instruction word.
- Sources data from the simple read bus toward the AXI bridge.
- Honours the fetch-side cancel: a cancelled transaction still drains the bus but is never returned.

Parameters:
- ADDR_W, 32, physical address width (tag 20 + index 8 + offset 4).
- DATA_W, 32, instruction and bus beat width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- inst_valid  in  1  fetch request; held high until data_ok.
- inst_tag  in  20  physical address [31:12].
- inst_index  in  8  physical address [11:4].
- inst_offset  in  4  physical address [3:0].
- inst_uncache  in  1  request must bypass any buffering.
- inst_cancel  in  1  flush/branch cancel of the current request.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  inst_rdata valid this cycle.
- inst_rdata  out  32  instruction word.
- rd_req  out  1  bus read request.
- rd_type  out  3  3'b010 word, 3'b100 16-byte line.
- rd_addr  out  32  bus read address.
- rd_rdy  in  1  bus accepted rd_req.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final return beat.
- ret_data  in  32  return beat data.

Behaviour:
- Reset values: state=IDLE, cancel_r=0, all outputs 0 (inst_rdata=0, rd_addr=0, rd_type=0).
- paddr = {inst_tag, inst_index, inst_offset}.
- States and transitions:
  - IDLE: inst_addr_ok = inst_valid && !inst_cancel. On accept, latch paddr and uncache, then go to ISSUE. inst_valid with inst_cancel in the same cycle is not accepted and the state stays IDLE.
  - ISSUE: rd_req=1, rd_type=3'b010, rd_addr=latched paddr. rd_req is held, and never withdrawn, until rd_rdy. On rd_rdy go to WAIT.
  - WAIT: on ret_valid, capture ret_data into the data register. On ret_valid && ret_last go to DONE.
  - DONE: inst_data_ok = !(cancel_r || inst_cancel) for exactly one cycle, then go to IDLE.
- cancel_r: set by inst_cancel in ISSUE, WAIT or DONE; cleared on entering IDLE. Cancel therefore never aborts a bus transaction; it only suppresses data_ok.
- inst_rdata is registered; it is stable in the data_ok cycle and holds its value afterwards.
- inst_valid still high in the cycle after DONE is treated as a new request (re-fetch of the same or a new pc).
- Minimum latency, with rd_rdy=1 and the return one cycle after acceptance: addr_ok at cycle T, data_ok at T+3.
- Throughput is one outstanding request at most; addr_ok is 0 outside IDLE.
- Unexpected ret_valid in IDLE or ISSUE is ignored.
- Reset mid-operation returns to IDLE. The bridge is reset by the same rst, so no beats are owed.

Optional Feature:
- Macro IFETCH_LINE_BUF_EN.
- With the macro: a one-entry 16-byte line buffer holds lb_valid, lb_tag=paddr[31:4] and four words.
  - Cacheable request (inst_uncache=0) that hits (lb_valid && tag match) in IDLE: addr_ok, then DONE on the next cycle with word paddr[3:2]. Latency is addr_ok at T, data_ok at T+1.
  - Cacheable miss: rd_type=3'b100, rd_addr={paddr[31:4],4'b0}. Beats fill words 0..3 in order, and the target word is captured. After the last beat, lb_valid=1 and lb_tag is updated.
  - A cancelled refill still completes the fill and sets lb_valid.
  - Uncached requests use the word path and never read or write the buffer.
  - lb_valid is cleared only on reset.
- Without the macro: every request uses the word path and no buffer storage is inferred.

Decomposition:
- Shared package:
  - state encoding IDLE/ISSUE/WAIT/DONE (2 bits);
  - RD_TYPE_WORD=3'b010 and RD_TYPE_LINE=3'b100;
  - line offset width 4 and words per line 4.
- One natural sub-module: ifetch_line_buf (storage, tag compare, beat counter). It is instantiated only under IFETCH_LINE_BUF_EN.

Test Plan:
- Basic fetch:
  - Stimulus: paddr=0x1C00_0000, rd_rdy=1, one-beat return 0x0280_0C21 two cycles after acceptance.
  - Required: addr_ok at T; rd_req with rd_addr=0x1C00_0000 and rd_type=3'b010; data_ok with rdata=0x0280_0C21 at T+3.
- Bus backpressure:
  - Stimulus: rd_rdy low for 5 cycles.
  - Required: rd_req and rd_addr stay constant, no addr_ok re-assertion, data_ok follows the return.
- Cancel during WAIT:
  - Stimulus: inst_cancel pulses one cycle in WAIT.
  - Required: the return beat is consumed, data_ok stays 0, the state returns to IDLE. A following request at 0x1C00_0004 completes normally with its own data.
- Cancel in the DONE cycle and cancel with inst_valid in IDLE:
  - Required: no data_ok in the DONE case; no addr_ok in the IDLE case.
- Reset mid-WAIT:
  - Stimulus: rst=0 for 1 cycle.
  - Required: all outputs 0 next cycle; the next request is accepted from IDLE.
- IFETCH_LINE_BUF_EN:
  - Stimulus: a miss at 0x1C00_0008 returns 4 beats A,B,C,D.
  - Required: rd_type=3'b100, rd_addr=0x1C00_0000, rdata=C. A subsequent fetch of 0x1C00_000C hits with rdata=D at T+1 and no rd_req. An uncached fetch of the same address issues a word read.
